seg_scan_ctrl: RTL and testbench

//  Scan scheduler for the 4-digit common-anode 7-segment display (score hundreds/tens/units + lives).

---
 rtl/seg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit 7-segment scan scheduler with guard bands, brightness, blink and lz blanking
module seg_scan_ctrl #(
    parameter int DWELL        = 16,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] digits_in,
    input  logic        upd_req,
    output logic        upd_ack,
    input  logic [1:0]  bright,
    input  logic [3:0]  blink_en,
    input  logic        lz_blank,
    output logic [3:0]  digit_anode,
    output logic [7:0]  segment,
    output logic        frame_start
);

    localparam int CW    = $clog2(DWELL);
    localparam int BW    = $clog2(2 * BLINK_FRAMES);
    localparam int QUANT = (DWELL - 2 * GUARD) / 4;

    localparam logic [CW-1:0] CYC_LAST   = CW'(DWELL - 1);
    localparam logic [CW:0]   GUARD_W    = (CW + 1)'(GUARD);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        PH_GUARD_PRE,
        PH_LIT,
        PH_DARK
    } phase_t;

    // scan position
    logic [1:0]    slot;
    logic [CW-1:0] cyc;

    // settings and digits held stable for a whole frame
    logic [15:0]   shadow;
    logic [1:0]    bright_q;
    logic [3:0]    blink_q;
    logic          lz_q;
    logic [BW-1:0] blink_cnt;
    logic          captured;

    // combinational view of the current scan position
    logic          frame_end;
    phase_t        phase;
    logic [CW:0]   lit_len;
    logic [CW:0]   lit_end;
    logic [CW:0]   cyc_w;
    logic [3:0]    cur_digit;
    logic          sup3;
    logic          sup2;
    logic          sup1;
    logic          lz_sup;
    logic          blink_off;
    logic          slot_dark;

    function automatic logic [7:0] seg_decode(input logic [3:0] val);
        logic [7:0] seg;
        case (val)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hBF;
        endcase
        return seg;
    endfunction

    assign frame_end = (slot == 2'd0) && (cyc == CYC_LAST);

    // slot/cycle counters: cycle runs 0..DWELL-1, slot walks 3,2,1,0 and wraps to 3
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot <= 2'd3;
            cyc  <= '0;
        end else if (cyc == CYC_LAST) begin
            cyc  <= '0;
            slot <= slot - 2'd1;
        end else begin
            cyc  <= cyc + 1'b1;
        end
    end

    // frame-boundary latch: settings, digit capture and blink frame count change only here
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow    <= 16'h0000;
            bright_q  <= 2'd3;
            blink_q   <= 4'h0;
            lz_q      <= 1'b0;
            blink_cnt <= '0;
            captured  <= 1'b0;
        end else begin
            captured <= frame_end && upd_req;
            if (frame_end) begin
                bright_q  <= bright;
                blink_q   <= blink_en;
                lz_q      <= lz_blank;
                blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
                if (upd_req) begin
                    shadow <= digits_in;
                end
            end
        end
    end

    // lit window length scales with brightness in quarters of the usable slot time
    always_comb begin
        lit_len = (CW + 1)'((int'(bright_q) + 1) * QUANT);
        lit_end = GUARD_W + lit_len;
        cyc_w   = {1'b0, cyc};
        if (cyc_w < GUARD_W) begin
            phase = PH_GUARD_PRE;
        end else if (cyc_w < lit_end) begin
            phase = PH_LIT;
        end else begin
            phase = PH_DARK;
        end
    end

    // digit select and whole-slot suppression (leading zeros chain from the left, blink per digit)
    always_comb begin
        case (slot)
            2'd3:    cur_digit = shadow[15:12];
            2'd2:    cur_digit = shadow[11:8];
            2'd1:    cur_digit = shadow[7:4];
            default: cur_digit = shadow[3:0];
        endcase
        sup3 = lz_q && (shadow[15:12] == 4'd0);
        sup2 = sup3 && (shadow[11:8] == 4'd0);
        sup1 = sup2 && (shadow[7:4] == 4'd0);
        case (slot)
            2'd3:    lz_sup = sup3;
            2'd2:    lz_sup = sup2;
            2'd1:    lz_sup = sup1;
            default: lz_sup = 1'b0;
        endcase
        blink_off = (blink_cnt >= BLINK_HALF);
        slot_dark = lz_sup || (blink_q[slot] && blink_off);
    end

    // registered outputs, one cycle behind the counters; segment only moves while anodes are off
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            digit_anode <= 4'hF;
            segment     <= 8'hFF;
            frame_start <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            frame_start <= (slot == 2'd3) && (cyc == '0);
            upd_ack     <= captured;
            if ((phase == PH_LIT) && !slot_dark) begin
                digit_anode <= ~(4'b0001 << slot);
                segment     <= seg_decode(cur_digit);
            end else begin
                digit_anode <= 4'hF;
                segment     <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic        CLK;
    logic        RST;
    logic [15:0] digits_in;
    logic        upd_req;
    logic        upd_ack;
    logic [1:0]  bright;
    logic [3:0]  blink_en;
    logic        lz_blank;
    logic [3:0]  digit_anode;
    logic [7:0]  segment;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    logic [3:0] rec_an  [0:63];
    logic [7:0] rec_sg  [0:63];
    logic       rec_fs  [0:63];
    logic       rec_ack [0:63];

    seg_scan_ctrl #(.DWELL(16), .GUARD(2), .BLINK_FRAMES(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .digits_in   (digits_in),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .bright      (bright),
        .blink_en    (blink_en),
        .lz_blank    (lz_blank),
        .digit_anode (digit_anode),
        .segment     (segment),
        .frame_start (frame_start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge CLK);
        while (frame_start !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("frame_start_timeout", {31'd0, frame_start}, 32'd1);
    endtask

    task automatic do_update(input logic [15:0] val);
        int n;
        digits_in = val;
        upd_req   = 1'b1;
        n = 0;
        @(negedge CLK);
        while (upd_ack !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("upd_ack_seen", {31'd0, upd_ack}, 32'd1);
        chk("ack_with_frame_start", {31'd0, frame_start}, 32'd1);
        upd_req   = 1'b0;
        digits_in = 16'hFFFF;
    endtask

    task automatic grab_frame();
        for (int k = 0; k < 64; k++) begin
            rec_an[k]  = digit_anode;
            rec_sg[k]  = segment;
            rec_fs[k]  = frame_start;
            rec_ack[k] = upd_ack;
            @(negedge CLK);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] e3, input logic [7:0] e2,
                               input logic [7:0] e1, input logic [7:0] e0,
                               input int lit, input logic ack0);
        logic [7:0] e;
        logic [3:0] ea;
        logic [7:0] es;
        logic       on;
        logic       efs;
        logic       eack;
        int         c;
        int         i;
        for (int k = 0; k < 64; k++) begin
            c = k % 16;
            i = 3 - k / 16;
            case (i)
                3:       e = e3;
                2:       e = e2;
                1:       e = e1;
                default: e = e0;
            endcase
            on = (e != 8'hFF) && (c >= 2) && (c < 2 + lit);
            ea = 4'hF;
            if (on) ea[i] = 1'b0;
            es   = on ? e : 8'hFF;
            efs  = (k == 0);
            eack = (k == 0) ? ack0 : 1'b0;
            chk($sformatf("%s k%0d anode/seg", name, k), {20'd0, rec_an[k], rec_sg[k]}, {20'd0, ea, es});
            chk($sformatf("%s k%0d fs/ack", name, k), {30'd0, rec_fs[k], rec_ack[k]}, {30'd0, efs, eack});
        end
    endtask

    initial begin
        int lit_cnt;
        RST       = 1'b1;
        digits_in = 16'h0000;
        upd_req   = 1'b0;
        bright    = 2'd3;
        blink_en  = 4'h0;
        lz_blank  = 1'b0;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_anode_seg", {20'd0, digit_anode, segment}, 32'h0000_0FFF);
        chk("rst_ack_fs", {30'd0, upd_ack, frame_start}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("first_frame_start", {31'd0, frame_start}, 32'd1);
        chk("first_out_blank", {20'd0, digit_anode, segment}, 32'h0000_0FFF);

        // mid-frame request with 1234 at full brightness
        repeat (20) @(negedge CLK);
        do_update(16'h1234);
        grab_frame();
        check_frame("b3_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99, 12, 1'b1);
        chk("no_second_ack", {31'd0, upd_ack}, 32'd0);

        // lowest brightness, all eights
        bright = 2'd0;
        do_update(16'h8888);
        grab_frame();
        check_frame("b0_8888", 8'h80, 8'h80, 8'h80, 8'h80, 3, 1'b1);
        lit_cnt = 0;
        for (int k = 0; k < 64; k++) if (rec_an[k] != 4'hF) lit_cnt++;
        chk("b0_lit_count", lit_cnt, 32'd12);

        // leading-zero suppression
        bright   = 2'd3;
        lz_blank = 1'b1;
        do_update(16'h0050);
        grab_frame();
        check_frame("lz_0050", 8'hFF, 8'hFF, 8'h92, 8'hC0, 12, 1'b1);
        do_update(16'h0000);
        grab_frame();
        check_frame("lz_0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0, 12, 1'b1);
        do_update(16'h0105);
        grab_frame();
        check_frame("lz_0105", 8'hFF, 8'hF9, 8'hC0, 8'h92, 12, 1'b1);

        // dash for non-BCD values, then a request dropped before the boundary
        lz_blank = 1'b0;
        do_update(16'hA7F0);
        grab_frame();
        check_frame("dash_A7F0", 8'hBF, 8'hF8, 8'hBF, 8'hC0, 12, 1'b1);
        repeat (10) @(negedge CLK);
        digits_in = 16'h1111;
        upd_req   = 1'b1;
        repeat (5) @(negedge CLK);
        upd_req = 1'b0;
        wait_fs();
        grab_frame();
        check_frame("dropped_req", 8'hBF, 8'hF8, 8'hBF, 8'hC0, 12, 1'b0);

        // reset during the lit phase of d1 with a request pending
        repeat (37) @(negedge CLK);
        chk("pre_rst_lit_d1", {20'd0, digit_anode, segment}, {20'd0, 4'b1101, 8'hBF});
        blink_en  = 4'b0001;
        digits_in = 16'h5555;
        upd_req   = 1'b1;
        #2 RST = 1'b1;
        #1;
        chk("rst_async_blank", {20'd0, digit_anode, segment}, 32'h0000_0FFF);
        chk("rst_async_ack_fs", {30'd0, upd_ack, frame_start}, 32'd0);
        upd_req = 1'b0;
        @(negedge CLK);
        chk("rst_hold_blank", {20'd0, digit_anode, segment}, 32'h0000_0FFF);
        chk("rst_hold_ack", {31'd0, upd_ack}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("restart_frame_start", {31'd0, frame_start}, 32'd1);

        // blink on d0 with two-frame half-period; shadow is back to 0000
        for (int f = 0; f < 6; f++) begin
            grab_frame();
            check_frame($sformatf("blink_f%0d", f), 8'hC0, 8'hC0, 8'hC0,
                        (f == 2 || f == 3) ? 8'hFF : 8'hC0, 12, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
